inner_wb_rr_arbiter: RTL and testbench
======================================

INNER_WB_RR_ARBITER -- requirements
Module: inner_wb_rr_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 24, Wishbone address width.
- TIMEOUT, 255, slave-silence cycles before an abort; legal range 1..255.
REQ-002 Ports SHALL be (directions are from the arbiter's view):
- i_clk  in  1  core clock, the only clock.
- i_rst  in  1  reset, synchronous, active-high.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe, write enable.
- m0_adr  in  ADDR_W  master 0 address.
- m0_sel  in  2  master 0 byte select.
- m0_o_dat  in  16  master 0 write data.
- m0_4_burst, m0_8_burst  in  1 each  master 0 burst hints.
- m0_ack, m0_err  out  1 each  master 0 acknowledge and error.
- m1_*  (same set)  master 1, identical widths and directions.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  downstream bus cycle, strobe, write enable.
- o_wb_adr  out  ADDR_W  downstream address.
- o_wb_sel  out  2  downstream byte select.
- o_wb_o_dat  out  16  downstream write data.
- o_wb_4_burst, o_wb_8_burst  out  1 each  downstream burst hints.
- i_wb_ack, i_wb_err  in  1 each  downstream acknowledge and error.
- o_owner  out  1  index of the granted master; valid only while o_busy=1.
- o_busy  out  1  grant held.
- o_timeout  out  1  one-cycle pulse when an abort fires.
REQ-003 Read data SHALL NOT pass through this block; it is fanned out externally.

Function
REQ-004 The state machine SHALL have three states: IDLE, GRANT, DRAIN.
REQ-005 IDLE, one master with cyc=1: that master becomes owner, next state GRANT.
REQ-006 IDLE, both masters with cyc=1: the master other than last_owner becomes owner (round robin).
REQ-007 last_owner SHALL update to the new owner on every grant.
REQ-008 GRANT, owner cyc=0: SHALL return to IDLE.
REQ-009 After any release there SHALL be at least one IDLE cycle before the next grant; the arbiter SHALL never switch masters directly GRANT->GRANT.
REQ-010 In GRANT, the downstream outputs (cyc, stb, we, adr, sel, o_dat, burst hints) SHALL be combinationally muxed from the owner.
REQ-011 In GRANT, o_wb_cyc SHALL equal owner_cyc and o_wb_stb SHALL equal owner_cyc & owner_stb.
REQ-012 In IDLE and DRAIN, o_wb_cyc and o_wb_stb SHALL be 0; the other downstream outputs SHALL be don't-care but held stable.
REQ-013 Owner ack/err SHALL equal i_wb_ack/i_wb_err combinationally in GRANT only; the non-owner's ack/err SHALL always be 0.
REQ-014 Grant latency: a request arriving at IDLE edge N SHALL drive o_wb_cyc from cycle N+1.
REQ-015 The grant SHALL be held across a whole burst; a burst SHALL never be split between masters.
REQ-016 Timeout counter (8-bit):
- cleared on entering GRANT and on any cycle with i_wb_ack or i_wb_err;
- increments each GRANT cycle with o_wb_stb=1 and no ack/err;
- saturates, never wraps.
REQ-017 When the counter equals TIMEOUT in GRANT, in that same cycle:
- owner err SHALL be 1;
- o_timeout SHALL be 1;
- o_wb_cyc and o_wb_stb SHALL be 0;
- next state SHALL be DRAIN.
REQ-018 DRAIN SHALL hold until the owner drops cyc, then go to IDLE; owner ack/err SHALL be 0 throughout DRAIN.
REQ-019 i_wb_ack or i_wb_err in the same cycle as the timeout compare SHALL win: normal passthrough, no abort.
REQ-020 i_wb_ack/i_wb_err arriving in IDLE or DRAIN SHALL be ignored (not forwarded).
REQ-021 o_busy SHALL be 1 in GRANT and DRAIN; o_owner SHALL hold its value until the next grant.

Reset
REQ-022 On i_rst=1 at a clock edge the block SHALL enter IDLE, set last_owner=1 (master 0 wins the first tie), and clear the timeout counter and owner.
REQ-023 While in reset all outputs SHALL be 0 from the cycle after the reset edge, including mid-burst and in DRAIN.
REQ-024 Masters SHALL NOT receive ack or err for a transfer cut off by reset.

Verification
REQ-025 Tie after reset: m0_cyc=m1_cyc=1 at the same edge -> o_owner=0; o_wb_cyc=1 one cycle later; o_wb_adr=m0_adr.
REQ-026 Alternation: both masters request continuously, each dropping cyc after 1 ack -> grant order 0,1,0,1 with exactly one IDLE cycle between grants.
REQ-027 Burst lock: m0 issues an 8-beat burst while m1 requests -> 8 acks forwarded to m0 only, m1_ack=0, m1 granted only after m0_cyc=0.
REQ-028 Timeout: TIMEOUT=4, slave never acks -> m0_err and o_timeout high on the 4th stalled cycle, o_wb_cyc=0 that cycle, DRAIN until m0_cyc=0.
REQ-029 Reset mid-burst: i_rst after beat 3 of 8 -> next cycle o_wb_cyc=0, o_busy=0, no further m0_ack; after reset, a tie grants m0.
REQ-030 Ack at deadline: i_wb_ack on the same cycle the counter reaches TIMEOUT -> ack forwarded, no err, no o_timeout, state stays GRANT.

Source files
------------

// File: rtl/inner_wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter with a slave-silence abort.
// Grants are locked for a whole cycle (bursts included); read data is fanned out elsewhere.
module inner_wb_rr_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [1:0]        m0_sel,
  input  logic [15:0]       m0_o_dat,
  input  logic              m0_4_burst,
  input  logic              m0_8_burst,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [1:0]        m1_sel,
  input  logic [15:0]       m1_o_dat,
  input  logic              m1_4_burst,
  input  logic              m1_8_burst,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [1:0]        o_wb_sel,
  output logic [15:0]       o_wb_o_dat,
  output logic              o_wb_4_burst,
  output logic              o_wb_8_burst,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  output logic              o_owner,
  output logic              o_busy,
  output logic              o_timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_e;

  localparam int          PAY_W   = 1 + ADDR_W + 2 + 16 + 2;
  localparam logic [7:0]  TMO_CMP = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic [PAY_W-1:0] hold_q, hold_d;

  logic [PAY_W-1:0] m0_pay, m1_pay, own_pay, bus_pay;
  logic             own_cyc, own_stb, in_grant, resp, stalled, abort;
  logic             bus_cyc, bus_stb, own_ack, own_err;
  logic [7:0]       stall_cnt;

  assign m0_pay = {m0_we, m0_adr, m0_sel, m0_o_dat, m0_4_burst, m0_8_burst};
  assign m1_pay = {m1_we, m1_adr, m1_sel, m1_o_dat, m1_4_burst, m1_8_burst};

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tmo_cnt_d    = tmo_cnt_q;
    hold_d       = hold_q;

    own_cyc  = owner_q ? m1_cyc : m0_cyc;
    own_stb  = owner_q ? m1_stb : m0_stb;
    own_pay  = owner_q ? m1_pay : m0_pay;
    in_grant = (state_q == GRANT) && !i_rst;
    resp     = i_wb_ack || i_wb_err;

    // stall_cnt is the silence count including the current stalled cycle.
    stall_cnt = (tmo_cnt_q == 8'hFF) ? 8'hFF : tmo_cnt_q + 8'd1;
    stalled   = in_grant && own_cyc && own_stb && !resp;
    abort     = stalled && (stall_cnt == TMO_CMP);

    bus_cyc = in_grant && own_cyc && !abort;
    bus_stb = bus_cyc && own_stb;
    bus_pay = in_grant ? own_pay : hold_q;
    own_ack = in_grant && i_wb_ack;
    own_err = in_grant && (i_wb_err || abort);

    unique case (state_q)
      IDLE: begin
        if (m0_cyc || m1_cyc) begin
          owner_d      = (m0_cyc && m1_cyc) ? !last_owner_q : m1_cyc;
          last_owner_d = owner_d;
          tmo_cnt_d    = 8'd0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        hold_d = own_pay;
        if (!own_cyc)   state_d = IDLE;
        else if (abort) state_d = DRAIN;
        if (resp)         tmo_cnt_d = 8'd0;
        else if (stalled) tmo_cnt_d = stall_cnt;
      end
      DRAIN: begin
        if (!own_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-high; all state (including the held bus payload) is cleared.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      tmo_cnt_q    <= 8'd0;
      hold_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tmo_cnt_q    <= tmo_cnt_d;
      hold_q       <= hold_d;
    end
  end

  assign o_wb_cyc = bus_cyc;
  assign o_wb_stb = bus_stb;
  assign {o_wb_we, o_wb_adr, o_wb_sel, o_wb_o_dat, o_wb_4_burst, o_wb_8_burst} = bus_pay;

  assign m0_ack    = own_ack && !owner_q;
  assign m0_err    = own_err && !owner_q;
  assign m1_ack    = own_ack && owner_q;
  assign m1_err    = own_err && owner_q;
  assign o_owner   = owner_q;
  assign o_busy    = (state_q != IDLE);
  assign o_timeout = abort;

endmodule

// File: tb/tb_inner_wb_rr_arbiter.sv
// Randomized and directed bench for inner_wb_rr_arbiter against a cycle-level
// reference model of the arbitration, lock and abort rules.
module tb_inner_wb_rr_arbiter;

  localparam int ADDR_W = 24;
  localparam int TMO    = 4;

  typedef struct packed {
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [1:0]        sel;
    logic [15:0]       dat;
    logic              b4;
    logic              b8;
  } mst_t;

  logic i_clk = 1'b0;
  logic i_rst;
  mst_t mi [2];
  logic i_wb_ack, i_wb_err;

  logic              m0_ack, m0_err, m1_ack, m1_err;
  logic              o_wb_cyc, o_wb_stb, o_wb_we, o_wb_4_burst, o_wb_8_burst;
  logic [ADDR_W-1:0] o_wb_adr;
  logic [1:0]        o_wb_sel;
  logic [15:0]       o_wb_o_dat;
  logic              o_owner, o_busy, o_timeout;

  always #5 i_clk = ~i_clk;

  inner_wb_rr_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .m0_cyc(mi[0].cyc), .m0_stb(mi[0].stb), .m0_we(mi[0].we), .m0_adr(mi[0].adr),
    .m0_sel(mi[0].sel), .m0_o_dat(mi[0].dat), .m0_4_burst(mi[0].b4), .m0_8_burst(mi[0].b8),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(mi[1].cyc), .m1_stb(mi[1].stb), .m1_we(mi[1].we), .m1_adr(mi[1].adr),
    .m1_sel(mi[1].sel), .m1_o_dat(mi[1].dat), .m1_4_burst(mi[1].b4), .m1_8_burst(mi[1].b8),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
    .o_wb_sel(o_wb_sel), .o_wb_o_dat(o_wb_o_dat), .o_wb_4_burst(o_wb_4_burst),
    .o_wb_8_burst(o_wb_8_burst), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_owner(o_owner), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference model: who holds the bus, whether it is being drained after an
  // abort, and how many consecutive silent strobe cycles the slave has left.
  bit          r_busy, r_drain, r_owner, r_last = 1'b1, prev_rst;
  int          r_silent;
  logic [44:0] r_hold;

  // Observations of the DUT used by the directed scenarios.
  int obs_ack [2];
  int obs_gap;
  int obs_own [$];
  int obs_gaps [$];
  bit obs_busy_prev;

  function automatic logic [44:0] pay(input int i);
    return {mi[i].we, mi[i].adr, mi[i].sel, mi[i].dat, mi[i].b4, mi[i].b8};
  endfunction

  task automatic cycle();
    bit          grant, oc, os, resp, abort, oa, oe, nw;
    logic [44:0] mux;
    logic [3:0]  exp_resp;
    @(negedge i_clk);
    mux   = pay(int'(r_owner));
    oc    = mi[r_owner].cyc;
    os    = mi[r_owner].stb;
    resp  = i_wb_ack || i_wb_err;
    grant = r_busy && !r_drain;
    abort = grant && oc && os && !resp && (r_silent + 1 == TMO);
    oa    = grant && i_wb_ack;
    oe    = grant && (i_wb_err || abort);
    exp_resp = r_owner ? {oa, oe, 2'b00} : {2'b00, oa, oe};
    if (!(i_rst && !prev_rst)) begin
      check("bus", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_o_dat, o_wb_4_burst, o_wb_8_burst},
            {grant && oc && !abort, grant && oc && os && !abort, grant ? mux : r_hold});
      check("resp", {m1_ack, m1_err, m0_ack, m0_err}, exp_resp);
      check("status", {o_busy, o_owner, o_timeout}, {r_busy, r_owner, abort});
    end
    if (m0_ack) obs_ack[0]++;
    if (m1_ack) obs_ack[1]++;
    if (!o_busy) obs_gap++;
    if (o_busy && !obs_busy_prev) begin
      obs_own.push_back(int'(o_owner));
      obs_gaps.push_back(obs_gap);
      obs_gap = 0;
    end
    obs_busy_prev = o_busy;

    @(posedge i_clk);
    prev_rst = i_rst;
    if (i_rst) begin
      r_busy = 0; r_drain = 0; r_owner = 0; r_last = 1; r_silent = 0; r_hold = '0;
    end else if (!r_busy) begin
      if (mi[0].cyc || mi[1].cyc) begin
        nw = (mi[0].cyc && mi[1].cyc) ? !r_last : mi[1].cyc;
        r_owner = nw; r_last = nw; r_busy = 1; r_drain = 0; r_silent = 0;
      end
    end else if (r_drain) begin
      if (!oc) begin r_busy = 0; r_drain = 0; end
    end else begin
      r_hold = mux;
      if (!oc) r_busy = 0;
      else if (abort) r_drain = 1;
      if (resp) r_silent = 0;
      else if (oc && os) r_silent = (r_silent < 255) ? r_silent + 1 : 255;
    end
    #1;
  endtask

  task automatic drive_m(input int i, input bit cyc, input bit stb, input bit b8);
    mi[i].cyc = cyc;
    mi[i].stb = stb;
    mi[i].we  = 1'($urandom_range(0, 1));
    mi[i].adr = ADDR_W'($urandom());
    mi[i].sel = 2'($urandom());
    mi[i].dat = 16'($urandom());
    mi[i].b4  = 1'b0;
    mi[i].b8  = b8;
  endtask

  task automatic do_reset();
    i_rst = 1; i_wb_ack = 0; i_wb_err = 0;
    drive_m(0, 1, 1, 0);
    drive_m(1, 1, 1, 0);
    cycle();
    cycle();
    i_rst = 0;
    drive_m(0, 0, 0, 0);
    drive_m(1, 0, 0, 0);
  endtask

  initial begin
    i_rst = 1; i_wb_ack = 0; i_wb_err = 0;
    drive_m(0, 0, 0, 0);
    drive_m(1, 0, 0, 0);
    do_reset();
    check("reset_busy", o_busy, 0);
    check("reset_cyc", o_wb_cyc, 0);

    // Tie straight after reset goes to master 0, bus driven the next cycle.
    drive_m(0, 1, 1, 0);
    drive_m(1, 1, 1, 0);
    cycle();
    check("tie_owner", o_owner, 0);
    check("tie_cyc", o_wb_cyc, 1);
    check("tie_adr", o_wb_adr, mi[0].adr);

    // Alternation: one ack per grant, owner drops then re-requests.
    do_reset();
    drive_m(0, 1, 1, 0);
    drive_m(1, 1, 1, 0);
    obs_own.delete();
    obs_gaps.delete();
    cycle();
    for (int k = 0; k < 4; k++) begin
      i_wb_ack = 1; cycle(); i_wb_ack = 0;
      mi[k % 2].cyc = 0; cycle();
      mi[k % 2].cyc = 1; cycle();
    end
    check("alt_count", obs_own.size() >= 4, 1);
    for (int k = 0; k < 4 && k < obs_own.size(); k++) begin
      check($sformatf("alt_owner%0d", k), obs_own[k], k % 2);
      if (k > 0) check($sformatf("alt_gap%0d", k), obs_gaps[k], 1);
    end

    // Burst lock: 8 beats to m0 with m1 waiting.
    do_reset();
    drive_m(0, 1, 1, 1);
    drive_m(1, 1, 1, 0);
    cycle();
    obs_ack[0] = 0; obs_ack[1] = 0;
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 1) == 1) cycle();
      i_wb_ack = 1; cycle(); i_wb_ack = 0;
    end
    check("burst_m0_acks", obs_ack[0], 8);
    check("burst_m1_acks", obs_ack[1], 0);
    check("burst_owner_during", o_owner, 0);
    drive_m(0, 0, 0, 0);
    cycle();
    cycle();
    check("burst_then_m1", {o_busy, o_owner}, 2'b11);

    // Timeout with a silent slave.
    do_reset();
    drive_m(0, 1, 1, 0);
    cycle();
    for (int s = 1; s <= TMO; s++) begin
      check($sformatf("tmo_pulse%0d", s), o_timeout, s == TMO);
      check($sformatf("tmo_err%0d", s), m0_err, s == TMO);
      check($sformatf("tmo_cyc%0d", s), o_wb_cyc, s != TMO);
      cycle();
    end
    for (int d = 0; d < 3; d++) begin
      check("drain_hold", {o_busy, o_wb_cyc, m0_ack, m0_err}, 4'b1000);
      cycle();
    end
    mi[0].cyc = 0;
    cycle();
    check("drain_exit", o_busy, 0);

    // Ack exactly at the deadline wins over the abort.
    do_reset();
    drive_m(0, 1, 1, 0);
    cycle();
    for (int s = 1; s < TMO; s++) cycle();
    i_wb_ack = 1;
    #1;
    check("deadline_ack", {m0_ack, m0_err, o_timeout, o_wb_cyc}, 4'b1001);
    cycle();
    i_wb_ack = 0;
    #1;
    check("deadline_stay", {o_busy, o_wb_cyc}, 2'b11);
    cycle();

    // Reset in the middle of a burst.
    do_reset();
    drive_m(0, 1, 1, 1);
    drive_m(1, 1, 1, 0);
    cycle();
    for (int b = 0; b < 3; b++) begin
      i_wb_ack = 1; cycle();
    end
    i_rst = 1;
    cycle();
    check("rst_mid_bus", {o_wb_cyc, o_busy, m0_ack, m0_err}, 4'b0000);
    cycle();
    i_rst = 0; i_wb_ack = 0;
    cycle();
    check("rst_then_tie", {o_busy, o_owner}, 2'b10);

    // Randomized traffic with varying slave responsiveness and sporadic resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) mi[i].cyc = ~mi[i].cyc;
        mi[i].stb = ($urandom_range(0, 3) != 0);
        mi[i].we  = 1'($urandom_range(0, 1));
        mi[i].adr = ADDR_W'($urandom());
        mi[i].sel = 2'($urandom());
        mi[i].dat = 16'($urandom());
        mi[i].b4  = 1'($urandom_range(0, 1));
        mi[i].b8  = 1'($urandom_range(0, 1));
      end
      i_wb_ack = ($urandom_range(0, 2 * ((c / 500) % 4) + 1) == 0);
      i_wb_err = ($urandom_range(0, 15) == 0);
      i_rst    = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
